// File: rtl/debug_trace_pkg.sv
// Shared types and constants for the debug trace display: entry layout,
// FSM states and the active-low hex-to-seven-segment table.
package debug_trace_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIGITS = 8;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] word;
    } trace_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

endpackage

// File: rtl/debug_trace_display_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_to_seg7
    import debug_trace_pkg::*;
(
    input  logic [3:0]       hex_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/debug_trace_display.sv
// Captures every distinct (addr, word) debug write into a FIFO and shows each
// entry for HOLD_CYCLES clocks. Optional address window: DEBUG_TRACE_ADDR_FILTER_EN.
module debug_trace_display
    import debug_trace_pkg::*;
#(
    parameter int unsigned       DEPTH       = 8,
    parameter int unsigned       HOLD_CYCLES = 20000000,
    parameter logic [ADDR_W-1:0] WIN_LO      = 12'h000,
    parameter logic [ADDR_W-1:0] WIN_HI      = 12'hFFF
) (
    input  logic                   clock,
    input  logic                   ctrl_reset,
    input  logic [ADDR_W-1:0]      debug_addr,
    input  logic [WORD_W-1:0]      debug_word,
    output logic [SEG_W-1:0]       seg1,
    output logic [SEG_W-1:0]       seg2,
    output logic [SEG_W-1:0]       seg3,
    output logic [SEG_W-1:0]       seg4,
    output logic [SEG_W-1:0]       seg5,
    output logic [SEG_W-1:0]       seg6,
    output logic [SEG_W-1:0]       seg7,
    output logic [SEG_W-1:0]       seg8,
    output logic [7:0]             leds,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

    trace_entry_t     prev_q;
    logic             prev_valid_q;
    trace_entry_t     mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    state_t           state_q;
    logic [TW-1:0]    timer_q;
    logic [SEG_W-1:0] seg_q [DIGITS];
    logic [7:0]       leds_q;

    trace_entry_t     cur_c;
    logic             win_ok_c;
    logic             push_c;
    logic             full_c;
    logic             pop_c;
    logic             wr_en_c;
    logic [SEG_W-1:0] seg_dec_c [DIGITS];

    assign cur_c = trace_entry_t'{addr: debug_addr, word: debug_word};

`ifdef DEBUG_TRACE_ADDR_FILTER_EN
    assign win_ok_c = (debug_addr >= WIN_LO) && (debug_addr <= WIN_HI);
`else
    assign win_ok_c = 1'b1;
`endif

    assign push_c  = win_ok_c && (!prev_valid_q || (cur_c != prev_q));
    assign full_c  = (count_q == FULL_CNT);
    // Pop whenever something is queued and nothing is mid-dwell
    assign pop_c   = (count_q != '0) && ((state_q == IDLE) || (timer_q == '0));
    assign wr_en_c = push_c && (!full_c || pop_c);

    for (genvar i = 0; i < DIGITS; i++) begin : g_dec
        hex_to_seg7 u_dec (
            .hex_i (mem_q[rd_ptr_q].word[4*i +: 4]),
            .seg_o (seg_dec_c[i])
        );
    end

    // Change detector, pointers, occupancy and sticky overflow
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            prev_q       <= cur_c;
            prev_valid_q <= 1'b1;
            if (wr_en_c) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_c)   rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(wr_en_c) - CW'(pop_c);
            if (push_c && full_c && !pop_c) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset && wr_en_c) mem_q[wr_ptr_q] <= cur_c;
    end

    // Dwell FSM; the display registers load straight from the FIFO head on pop
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            leds_q  <= '0;
            for (int i = 0; i < DIGITS; i++) seg_q[i] <= SEG_BLANK;
        end else begin
            case (state_q)
                IDLE:    if (pop_c) state_q <= SHOW;
                SHOW:    if ((timer_q == '0) && !pop_c) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (pop_c) begin
                timer_q <= HOLD_LAST;
                leds_q  <= mem_q[rd_ptr_q].addr[7:0];
                for (int i = 0; i < DIGITS; i++) seg_q[i] <= seg_dec_c[i];
            end else if (timer_q != '0) begin
                timer_q <= timer_q - TW'(1);
            end
        end
    end

    assign seg1       = seg_q[0];
    assign seg2       = seg_q[1];
    assign seg3       = seg_q[2];
    assign seg4       = seg_q[3];
    assign seg5       = seg_q[4];
    assign seg6       = seg_q[5];
    assign seg7       = seg_q[6];
    assign seg8       = seg_q[7];
    assign leds       = leds_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_debug_trace_display.sv
// Randomised bench for debug_trace_display against a queue-based model of
// the trace buffer and its fixed-dwell display.
`timescale 1ns/1ps
module tb_debug_trace_display;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned HOLD  = 4;
    localparam logic [11:0] WIN_LO = 12'h010;
    localparam logic [11:0] WIN_HI = 12'h01F;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] addr = '0;
    logic [31:0] word = '0;
    logic [6:0]  seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8;
    logic [7:0]  leds;
    logic [3:0]  fifo_count;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    debug_trace_display #(
        .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .WIN_LO(WIN_LO), .WIN_HI(WIN_HI)
    ) dut (
        .clock(clk), .ctrl_reset(rst), .debug_addr(addr), .debug_word(word),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
        .seg5(seg5), .seg6(seg6), .seg7(seg7), .seg8(seg8),
        .leds(leds), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: queue of pending entries plus how long the current one has been shown
    logic [43:0] m_q [$];
    logic [11:0] m_prev_a;
    logic [31:0] m_prev_w;
    bit          m_have_prev;
    bit          m_active;
    int          m_shown;
    logic [6:0]  m_seg [8];
    logic [7:0]  m_leds;
    bit          m_ovf;
    int          m_simul;

    function automatic bit in_window(logic [11:0] a);
`ifdef DEBUG_TRACE_ADDR_FILTER_EN
        return (a >= WIN_LO) && (a <= WIN_HI);
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit pop_due();
        return (m_q.size() != 0) && (!m_active || (m_shown >= HOLD));
    endfunction

    always @(posedge clk) begin : model
        bit full, pop, chg;
        logic [43:0] e;
        if (rst) begin
            m_q.delete();
            m_have_prev = 1'b0;
            m_active    = 1'b0;
            m_shown     = 0;
            m_leds      = '0;
            m_ovf       = 1'b0;
            for (int k = 0; k < 8; k++) m_seg[k] = 7'h7F;
        end else begin
            full = (m_q.size() == DEPTH);
            pop  = pop_due();
            chg  = (!m_have_prev || ({addr, word} != {m_prev_a, m_prev_w})) && in_window(addr);
            if (pop) begin
                e = m_q.pop_front();
                for (int k = 0; k < 8; k++) m_seg[k] = HEX[e[4*k +: 4]];
                m_leds   = e[39:32];
                m_active = 1'b1;
                m_shown  = 1;
            end else if (m_active) begin
                if (m_shown >= HOLD) m_active = 1'b0;
                else m_shown++;
            end
            if (chg) begin
                if (!full || pop) m_q.push_back({addr, word});
                else m_ovf = 1'b1;
                if (full && pop) m_simul++;
            end
            m_prev_a    = addr;
            m_prev_w    = word;
            m_have_prev = 1'b1;
        end
    end

    function automatic logic [68:0] obs_vec();
        return {seg8, seg7, seg6, seg5, seg4, seg3, seg2, seg1, leds, fifo_count, overflow};
    endfunction

    function automatic logic [68:0] exp_vec();
        return {m_seg[7], m_seg[6], m_seg[5], m_seg[4], m_seg[3], m_seg[2], m_seg[1], m_seg[0],
                m_leds, 4'(m_q.size()), m_ovf};
    endfunction

    task automatic test_reset();
        rst = 1'b1; addr = '0; word = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_vec() !== {{8{7'h7F}}, 8'h00, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), {{8{7'h7F}}, 8'h00, 4'd0, 1'b0});
        end
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_first_sample cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (seg1 !== 7'h40 || seg8 !== 7'h40 || leds !== 8'h00 || fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_zero_shown: got seg1=%h seg8=%h leds=%h cnt=%0d expected 40 40 00 0",
                     seg1, seg8, leds, fifo_count);
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < HOLD + 2; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL single_settle cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        addr = 12'h01A; word = 32'hDEADBEEF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL single_latency cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({seg8, seg7, seg6, seg5, seg4, seg3, seg2, seg1, leds} !==
            {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E, 8'h1A}) begin
            failures++;
            $display("FAIL single_deadbeef: got %h expected %h",
                     {seg8, seg7, seg6, seg5, seg4, seg3, seg2, seg1, leds},
                     {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E, 8'h1A});
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL single_hold cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (seg1 !== 7'h0E || leds !== 8'h1A || fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL single_retained: got seg1=%h leds=%h cnt=%0d expected 0e 1a 0", seg1, leds, fifo_count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL overflow_fill cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            addr = 12'(12'h100 + i);
            word = $urandom;
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL overflow_drain cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL overflow_sticky: got ovf=%b cnt=%0d expected 1 0", overflow, fifo_count);
        end
    endtask

    task automatic test_full_simul();
        bit flag = 1'b0;
        int n = 0;
        int start_simul;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_simul = m_simul;
        for (int c = 0; c < 60; c++) begin
            bit full_now;
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL full_simul cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            if (flag) begin
                checks++;
                if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL full_push_pop cyc%0d: got cnt=%0d ovf=%b expected 8 0", c, fifo_count, overflow);
                end
            end
            full_now = (m_q.size() == DEPTH);
            flag = 1'b0;
            if (!full_now || pop_due()) begin
                n++;
                addr = 12'(12'h200 + n);
                word = $urandom;
                flag = full_now;
            end
        end
        checks++;
        if (m_simul == start_simul || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_simul_reached: got events=%0d ovf=%b expected >0 0", m_simul - start_simul, overflow);
        end
    endtask

    task automatic test_reset_mid();
        bit reached = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            addr = 12'(12'h300 + c);
            word = $urandom;
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_mid_fill cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            if (m_q.size() == 5 && m_active) reached = 1'b1;
        end
        checks++;
        if (!reached || fifo_count !== 4'd5) begin
            failures++;
            $display("FAIL reset_mid_count5: got cnt=%0d reached=%b expected 5 1", fifo_count, reached);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (obs_vec() !== {{8{7'h7F}}, 8'h00, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_clear: got %h expected %h", obs_vec(), {{8{7'h7F}}, 8'h00, 4'd0, 1'b0});
        end
        @(negedge clk);
        checks++;
        if (fifo_count !== 4'd1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_mid_first_sample: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_filter();
        rst = 1'b1; addr = '0; word = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL filter_settle cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        addr = 12'h00F; word = $urandom;
        @(negedge clk);
        addr = 12'h020; word = $urandom;
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL filter_outside: got %h expected %h", obs_vec(), exp_vec());
        end
`ifdef DEBUG_TRACE_ADDR_FILTER_EN
        checks++;
        if (fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL filter_no_push: got cnt=%0d expected 0", fifo_count);
        end
`endif
        addr = 12'h015; word = $urandom;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL filter_inside cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (leds !== 8'h15 || seg1 !== HEX[word[3:0]] || fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL filter_shown: got leds=%h seg1=%h cnt=%0d expected 15 %h 0",
                     leds, seg1, fifo_count, HEX[word[3:0]]);
        end
    endtask

    initial begin
        m_simul = 0;
        test_reset();
        test_single();
        test_overflow();
        test_full_simul();
        test_reset_mid();
        test_filter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
